// File: rtl/clk_div_multi.sv
// clk_div_multi: multi-channel programmable clock divider with glitch-free run-time reprogramming
module clk_div_multi #(
  parameter int CHANNELS  = 4,
  parameter int CNT_WIDTH = 8,
  localparam int CHW      = CHANNELS > 1 ? $clog2(CHANNELS) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cfg_valid,
  output logic                 cfg_ready,
  input  logic [CHW-1:0]       cfg_chan,
  input  logic [CNT_WIDTH-1:0] cfg_div,
  input  logic                 cfg_en,
  output logic [CHANNELS-1:0]  out,
  output logic [CHANNELS-1:0]  tick
);
  localparam int PADW = 1 << CHW;
  logic [CHANNELS-1:0]  en, pending, pend_en, acc, term;
  logic [CNT_WIDTH-1:0] cur_div [CHANNELS];
  logic [CNT_WIDTH-1:0] cnt [CHANNELS];
  logic [CNT_WIDTH-1:0] pend_div [CHANNELS];
  logic [PADW-1:0]      pend_pad;
  logic                 run_req;
  // channels beyond CHANNELS read as never-pending, so writes to them are accepted and dropped
  assign pend_pad  = PADW'(pending);
  assign cfg_ready = ~pend_pad[cfg_chan];
  assign run_req   = cfg_en & (cfg_div != '0);
  // per-channel accept strobe and terminal-count detect
  always_comb begin
    acc  = '0;
    term = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      acc[k]  = cfg_valid & cfg_ready & (cfg_chan == CHW'(k));
      term[k] = en[k] & (cnt[k] == cur_div[k] - CNT_WIDTH'(1));
    end
  end
  // channel state: start stopped channels at once, defer changes to running ones until terminal count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en      <= '0;
      pending <= '0;
      pend_en <= '0;
      out     <= '0;
      tick    <= '0;
      for (int k = 0; k < CHANNELS; k++) begin
        cur_div[k]  <= '0;
        cnt[k]      <= '0;
        pend_div[k] <= '0;
      end
    end else begin
      for (int k = 0; k < CHANNELS; k++) begin
        tick[k] <= term[k];
        if (!en[k]) begin
          if (acc[k] && run_req) begin
            en[k]      <= 1'b1;
            cur_div[k] <= cfg_div;
            cnt[k]     <= '0;
          end
        end else begin
          if (acc[k]) begin
            pending[k]  <= 1'b1;
            pend_div[k] <= cfg_div;
            pend_en[k]  <= run_req;
          end
          if (term[k]) begin
            cnt[k] <= '0;
            out[k] <= (pending[k] & ~pend_en[k]) ? 1'b0 : ~out[k];
            if (pending[k]) begin
              pending[k] <= 1'b0;
              en[k]      <= pend_en[k];
              if (pend_en[k]) cur_div[k] <= pend_div[k];
            end
          end else begin
            cnt[k] <= cnt[k] + CNT_WIDTH'(1);
          end
        end
      end
    end
  end
`ifdef FORMAL
  logic past_ok;
  // marks cycles where $past refers to a post-reset state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) past_ok <= 1'b0;
    else past_ok <= 1'b1;
  end
  for (genvar i = 0; i < CHANNELS; i++) begin : g_fv
    // output only moves with a tick, ticks are isolated for half-periods above one, counter stays in range
    always @(posedge clk) begin
      if (past_ok && rst_n) begin
        if (out[i] != $past(out[i])) assert (tick[i]);
        if (tick[i] && $past(tick[i])) assert (cur_div[i] <= 1 || $past(cur_div[i]) <= 1);
        if (en[i]) assert (cnt[i] < cur_div[i]);
      end
    end
  end
`endif
endmodule

// File: tb/tb_clk_div_multi.sv
// tb_clk_div_multi: table vectors, corner sequences and random traffic against a toggle-schedule model
module tb_clk_div_multi;
  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       cfg_valid = 1'b0, cfg_en = 1'b0, cfg_ready;
  logic [1:0] cfg_chan = '0;
  logic [7:0] cfg_div = '0;
  logic [3:0] out, tick;
  logic       v3 = 1'b0, ready3;
  logic [2:0] out3, tick3;
  int vectors = 0, miscompares = 0;

  clk_div_multi #(.CHANNELS(4), .CNT_WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_chan(cfg_chan), .cfg_div(cfg_div), .cfg_en(cfg_en), .out(out), .tick(tick)
  );
  clk_div_multi #(.CHANNELS(3), .CNT_WIDTH(4)) dut3 (
    .clk(clk), .rst_n(rst_n), .cfg_valid(v3), .cfg_ready(ready3),
    .cfg_chan(cfg_chan), .cfg_div(cfg_div[3:0]), .cfg_en(cfg_en), .out(out3), .tick(tick3)
  );

  always #5 clk = ~clk;

  // model: each running channel has a half-period and the absolute edge number of its next toggle
  int m_t;
  bit m_run[4], m_o[4], m_tk[4], m_hp[4], m_pr[4];
  int m_d[4], m_nxt[4], m_pd[4];

  task automatic m_reset();
    m_t = 0;
    for (int k = 0; k < 4; k++) begin
      m_run[k] = 0; m_o[k] = 0; m_tk[k] = 0; m_hp[k] = 0; m_pr[k] = 0;
      m_d[k] = 0; m_nxt[k] = 0; m_pd[k] = 0;
    end
  endtask

  function automatic bit m_ready(int ch);
    return (ch >= 4) || !m_hp[ch];
  endfunction

  task automatic m_edge(bit v, int ch, int dv, bit e);
    bit acc, was_run;
    acc = v && m_ready(ch);
    was_run = m_run[ch];
    m_t++;
    for (int k = 0; k < 4; k++) begin
      m_tk[k] = 0;
      if (m_run[k] && m_t == m_nxt[k]) begin
        m_tk[k] = 1;
        if (m_hp[k] && !m_pr[k]) begin
          m_o[k] = 0;
          m_run[k] = 0;
        end else begin
          m_o[k] = !m_o[k];
          if (m_hp[k]) m_d[k] = m_pd[k];
          m_nxt[k] = m_t + m_d[k];
        end
        m_hp[k] = 0;
      end
    end
    if (acc) begin
      if (was_run) begin
        m_hp[ch] = 1; m_pr[ch] = e && dv != 0; m_pd[ch] = dv;
      end else if (e && dv != 0) begin
        m_run[ch] = 1; m_d[ch] = dv; m_nxt[ch] = m_t + dv;
      end
    end
  endtask

  function automatic logic [3:0] m_out();
    logic [3:0] r;
    for (int k = 0; k < 4; k++) r[k] = m_o[k];
    return r;
  endfunction

  function automatic logic [3:0] m_tick();
    logic [3:0] r;
    for (int k = 0; k < 4; k++) r[k] = m_tk[k];
    return r;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s at %0t: actual=%0h required=%0h", name, $time, act, req);
    end
  endtask

  // one clock: drive config, check ready before the edge, outputs after it
  task automatic step(input bit v, input int ch, input int dv, input bit e, output logic rdy);
    @(negedge clk);
    cfg_valid = v; cfg_chan = ch[1:0]; cfg_div = dv[7:0]; cfg_en = e;
    #1;
    rdy = cfg_ready;
    chk("cfg_ready", 32'(cfg_ready), 32'(m_ready(ch)));
    @(posedge clk);
    m_edge(v, ch, dv, e);
    #1;
    chk("out", 32'(out), 32'(m_out()));
    chk("tick", 32'(tick), 32'(m_tick()));
  endtask

  typedef struct {
    bit v; int ch; int dv; bit e; bit r; logic [3:0] o; logic [3:0] t;
  } vec_t;
  vec_t tbl[16];
  logic rdy;

  initial begin
    tbl[0]  = '{1, 0, 3, 1, 1, 4'h0, 4'h0};
    tbl[1]  = '{0, 0, 0, 0, 1, 4'h0, 4'h0};
    tbl[2]  = '{0, 0, 0, 0, 1, 4'h0, 4'h0};
    tbl[3]  = '{0, 0, 0, 0, 1, 4'h1, 4'h1};
    tbl[4]  = '{0, 0, 0, 0, 1, 4'h1, 4'h0};
    tbl[5]  = '{0, 0, 0, 0, 1, 4'h1, 4'h0};
    tbl[6]  = '{0, 0, 0, 0, 1, 4'h0, 4'h1};
    tbl[7]  = '{0, 0, 0, 0, 1, 4'h0, 4'h0};
    tbl[8]  = '{0, 0, 0, 0, 1, 4'h0, 4'h0};
    tbl[9]  = '{0, 0, 0, 0, 1, 4'h1, 4'h1};
    tbl[10] = '{1, 0, 3, 0, 1, 4'h1, 4'h0};
    tbl[11] = '{0, 0, 0, 0, 0, 4'h1, 4'h0};
    tbl[12] = '{0, 0, 0, 0, 0, 4'h0, 4'h1};
    tbl[13] = '{0, 0, 0, 0, 1, 4'h0, 4'h0};
    tbl[14] = '{1, 1, 0, 1, 1, 4'h0, 4'h0};
    tbl[15] = '{0, 1, 0, 0, 1, 4'h0, 4'h0};
    m_reset();
    #2 rst_n = 1'b0;
    #1;
    chk("reset_out", 32'(out), 32'h0);
    chk("reset_tick", 32'(tick), 32'h0);
    chk("reset_ready", 32'(cfg_ready), 32'h1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int n = 0; n < 16; n++) begin
      step(tbl[n].v, tbl[n].ch, tbl[n].dv, tbl[n].e, rdy);
      chk($sformatf("tbl%0d_ready", n), 32'(rdy), 32'(tbl[n].r));
      chk($sformatf("tbl%0d_out", n), 32'(out), 32'(tbl[n].o));
      chk($sformatf("tbl%0d_tick", n), 32'(tick), 32'(tbl[n].t));
    end
    step(1, 1, 2, 1, rdy);
    step(0, 0, 0, 0, rdy);
    step(0, 0, 0, 0, rdy);
    step(0, 0, 0, 0, rdy);
    step(1, 1, 5, 1, rdy);
    repeat (25) step(0, 1, 0, 0, rdy);
    step(1, 2, 255, 1, rdy);
    step(1, 3, 1, 1, rdy);
    repeat (600) step(0, 2, 0, 0, rdy);
    step(1, 3, 0, 0, rdy);
    repeat (4) step(0, 3, 0, 0, rdy);
    for (int n = 0; n < 3000; n++) begin
      int dv;
      dv = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 6));
      step($urandom_range(0, 3) == 0, int'($urandom_range(0, 3)), dv, $urandom_range(0, 4) != 0, rdy);
    end
    step(1, 0, 4, 1, rdy);
    step(1, 1, 1, 1, rdy);
    step(0, 0, 0, 0, rdy);
    step(0, 0, 0, 0, rdy);
    step(1, 0, 7, 1, rdy);
    step(0, 0, 0, 0, rdy);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_out", 32'(out), 32'h0);
    chk("async_rst_tick", 32'(tick), 32'h0);
    m_reset();
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step(0, k, 0, 0, rdy);
      chk("post_rst_ready", 32'(rdy), 32'h1);
    end
    @(negedge clk);
    cfg_valid = 1'b0; v3 = 1'b1; cfg_chan = 2'd3; cfg_div = 8'd5; cfg_en = 1'b1;
    #1;
    chk("oor_ready", 32'(ready3), 32'h1);
    repeat (8) @(posedge clk);
    #1;
    chk("oor_out", 32'(out3), 32'h0);
    chk("oor_tick", 32'(tick3), 32'h0);
    v3 = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
